// File: rtl/kernel_loader.sv
// Kernel loader: buffers one lane of weight triples, then replays them as a contiguous burst per shifter lane.
// Optional abort input is enabled by defining KERNEL_LOADER_ABORT_EN.
module kernel_loader #(
  parameter int IO_DATA_WIDTH = 16,
  parameter int NB_LANES      = 12,
  parameter int LOAD_CYCLES   = 8
) (
  input  logic                     clk,
  input  logic                     arst_n_in,
  input  logic                     start,
`ifdef KERNEL_LOADER_ABORT_EN
  input  logic                     abort,
`endif
  input  logic [IO_DATA_WIDTH-1:0] din_1,
  input  logic [IO_DATA_WIDTH-1:0] din_2,
  input  logic [IO_DATA_WIDTH-1:0] din_3,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic [IO_DATA_WIDTH-1:0] v_1,
  output logic [IO_DATA_WIDTH-1:0] v_2,
  output logic [IO_DATA_WIDTH-1:0] v_3,
  output logic [NB_LANES-1:0]      LE_select,
  output logic                     busy,
  output logic                     done
);

  localparam int CW = $clog2(LOAD_CYCLES);
  localparam int LW = (NB_LANES > 1) ? $clog2(NB_LANES) : 1;
  localparam int TW = 3 * IO_DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [LW-1:0]     lane_q, lane_d;
  logic [CW-1:0]     fill_cnt_q, fill_cnt_d;
  logic [CW-1:0]     burst_cnt_q, burst_cnt_d;
  logic [TW-1:0]     v_q, v_d;
  logic [NB_LANES-1:0] le_q, le_d;
  logic              din_ready_q, din_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [TW-1:0]     buf_q [LOAD_CYCLES];
  logic [TW-1:0]     buf_d [LOAD_CYCLES];
  logic              xfer;
  logic              abort_req;
  logic [CW-1:0]     next_idx;

`ifdef KERNEL_LOADER_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign xfer     = din_valid && din_ready_q;
  assign next_idx = burst_cnt_q + CW'(1);

  always_comb begin
    buf_d = buf_q;
    if (xfer) begin
      buf_d[fill_cnt_q] = {din_1, din_2, din_3};
    end
  end

  // Buffer contents are don't-care after reset, so it carries no reset term.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    fill_cnt_d  = fill_cnt_q;
    burst_cnt_d = burst_cnt_q;
    v_d         = v_q;
    le_d        = le_q;
    din_ready_d = din_ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = FILL;
          lane_d      = '0;
          fill_cnt_d  = '0;
          busy_d      = 1'b1;
          din_ready_d = 1'b1;
        end
      end
      FILL: begin
        if (xfer) begin
          fill_cnt_d = fill_cnt_q + CW'(1);
          // Entry 0 was written on an earlier edge, so the burst can start straight from it.
          if (fill_cnt_q == CW'(LOAD_CYCLES - 1)) begin
            state_d     = BURST;
            burst_cnt_d = '0;
            din_ready_d = 1'b0;
            le_d        = NB_LANES'(1) << lane_q;
            v_d         = buf_q[0];
          end
        end
      end
      BURST: begin
        if (burst_cnt_q == CW'(LOAD_CYCLES - 1)) begin
          le_d        = '0;
          burst_cnt_d = '0;
          if (lane_q == LW'(NB_LANES - 1)) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            lane_d  = '0;
          end else begin
            state_d     = FILL;
            lane_d      = lane_q + LW'(1);
            fill_cnt_d  = '0;
            din_ready_d = 1'b1;
          end
        end else begin
          burst_cnt_d = next_idx;
          v_d         = buf_q[next_idx];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort drops the load without a done pulse; v holds so the shifter keeps recirculating.
    if (abort_req && (state_q == FILL || state_q == BURST)) begin
      state_d     = IDLE;
      lane_d      = '0;
      fill_cnt_d  = '0;
      burst_cnt_d = '0;
      v_d         = v_q;
      le_d        = '0;
      din_ready_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q     <= IDLE;
      lane_q      <= '0;
      fill_cnt_q  <= '0;
      burst_cnt_q <= '0;
      v_q         <= '0;
      le_q        <= '0;
      din_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      fill_cnt_q  <= fill_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      v_q         <= v_d;
      le_q        <= le_d;
      din_ready_q <= din_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign v_1       = v_q[TW-1:2*IO_DATA_WIDTH];
  assign v_2       = v_q[2*IO_DATA_WIDTH-1:IO_DATA_WIDTH];
  assign v_3       = v_q[IO_DATA_WIDTH-1:0];
  assign LE_select = le_q;
  assign din_ready = din_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_kernel_loader.sv
// Directed bench for kernel_loader: full loads, input stalls, ignored starts, mid-burst reset.
// The abort scenario is exercised only when KERNEL_LOADER_ABORT_EN is defined.
module tb_kernel_loader;

  localparam int W  = 16;
  localparam int NB = 12;
  localparam int LC = 8;
  localparam int FULL_LOAD_DONE = NB * 2 * LC;

  logic          clk;
  logic          arst_n_in;
  logic          start;
`ifdef KERNEL_LOADER_ABORT_EN
  logic          abort;
`endif
  logic [W-1:0]  din_1, din_2, din_3;
  logic          din_valid;
  logic          din_ready;
  logic [W-1:0]  v_1, v_2, v_3;
  logic [NB-1:0] LE_select;
  logic          busy;
  logic          done;

  int tests;
  int fails;
  int seed;
  int n_in;
  int cyc;
  int dc;
  logic [W-1:0] last_v1, last_v2, last_v3;

  kernel_loader #(
    .IO_DATA_WIDTH(W),
    .NB_LANES(NB),
    .LOAD_CYCLES(LC)
  ) dut (
    .clk(clk),
    .arst_n_in(arst_n_in),
    .start(start),
`ifdef KERNEL_LOADER_ABORT_EN
    .abort(abort),
`endif
    .din_1(din_1),
    .din_2(din_2),
    .din_3(din_3),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .v_1(v_1),
    .v_2(v_2),
    .v_3(v_3),
    .LE_select(LE_select),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] word(input int idx, input int row);
    return W'(seed + 3 * idx + row);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic driveDin();
    din_1 = word(n_in, 0);
    din_2 = word(n_in, 1);
    din_3 = word(n_in, 2);
  endtask

  // One clock: the handshake seen before the edge decides whether the next triple is presented.
  task automatic applyStimulus();
    bit xfer;
    xfer = din_valid && din_ready;
    @(posedge clk);
    #1;
    if (xfer) begin
      n_in++;
      driveDin();
    end
    cyc++;
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_le"}, LE_select, '0);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_done"}, done, 1'b0);
    checkOutput({tag, "_rdy"}, din_ready, 1'b0);
  endtask

  task automatic checkVHold(input string tag);
    checkOutput({tag, "_v1"}, v_1, last_v1);
    checkOutput({tag, "_v2"}, v_2, last_v2);
    checkOutput({tag, "_v3"}, v_3, last_v3);
  endtask

  task automatic checkBurstWord(input int lane, input int idx);
    logic [NB-1:0] exp_le;
    exp_le = {{(NB-1){1'b0}}, 1'b1} << lane;
    checkOutput("burst_le", LE_select, exp_le);
    checkOutput("burst_v1", v_1, word(idx, 0));
    checkOutput("burst_v2", v_2, word(idx, 1));
    checkOutput("burst_v3", v_3, word(idx, 2));
    last_v1 = word(idx, 0);
    last_v2 = word(idx, 1);
    last_v3 = word(idx, 2);
  endtask

  // mode 0 plain, 1 random stalls, 2 stray starts, 3 reset in lane 5 burst, 4 abort in lane 2 burst
  task automatic runLoad(input int mode, output int done_cyc);
    int  bpos;
    int  lane;
    bit  fin;
    bit  exp_done;
    done_cyc  = -1;
    bpos      = 0;
    lane      = 0;
    fin       = 1'b0;
    n_in      = 0;
    driveDin();
    din_valid = 1'b1;
    start     = 1'b1;
    applyStimulus();
    start = 1'b0;
    cyc   = 0;
    checkOutput("start_busy", busy, 1'b1);
    checkOutput("start_rdy", din_ready, 1'b1);
    checkOutput("start_le", LE_select, '0);
    while (!fin && cyc < 1000) begin
      if (mode == 1) din_valid = 1'($urandom_range(0, 1));
      if (mode == 2) start = (cyc == 3 || cyc == 10 || cyc == 50 || cyc == 191);
      applyStimulus();
      start = 1'b0;
      if (bpos == LC) begin
        checkOutput("burst_end_le", LE_select, '0);
        checkVHold("burst_end_hold");
        lane++;
        bpos = 0;
      end else if (bpos > 0) begin
        checkBurstWord(lane, lane * LC + bpos);
        bpos++;
      end else if (LE_select != '0) begin
        checkBurstWord(lane, lane * LC);
        bpos = 1;
      end else begin
        checkVHold("gap_hold");
      end
      if (mode == 3 && lane == 5 && bpos == 3) begin
        #2 arst_n_in = 1'b0;
        #1;
        checkQuiet("rst_imm");
        checkOutput("rst_imm_v1", v_1, '0);
        checkOutput("rst_imm_v3", v_3, '0);
        last_v1 = '0;
        last_v2 = '0;
        last_v3 = '0;
        @(negedge clk);
        arst_n_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
          applyStimulus();
          checkQuiet("rst_after");
          checkVHold("rst_after_hold");
        end
        fin = 1'b1;
      end
`ifdef KERNEL_LOADER_ABORT_EN
      if (mode == 4 && lane == 2 && bpos == 5) begin
        abort = 1'b1;
        applyStimulus();
        abort = 1'b0;
        checkQuiet("abort_next");
        checkVHold("abort_hold");
        for (int i = 0; i < 4; i++) begin
          applyStimulus();
          checkQuiet("abort_after");
        end
        fin = 1'b1;
      end
`endif
      if (!fin) begin
        exp_done = (lane == NB);
        checkOutput("done", done, exp_done);
        checkOutput("busy", busy, !exp_done);
        checkOutput("din_ready", din_ready, (!exp_done && bpos == 0));
        if (exp_done) begin
          done_cyc = cyc;
          fin      = 1'b1;
          if (mode == 2) start = 1'b1;
          applyStimulus();
          start = 1'b0;
          checkQuiet("post_done");
        end
      end
    end
    checkOutput("load_finished", fin, 1'b1);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    seed      = 0;
    n_in      = 0;
    cyc       = 0;
    last_v1   = '0;
    last_v2   = '0;
    last_v3   = '0;
    arst_n_in = 1'b0;
    start     = 1'b0;
`ifdef KERNEL_LOADER_ABORT_EN
    abort     = 1'b0;
`endif
    din_valid = 1'b0;
    driveDin();

    #12;
    checkQuiet("reset");
    checkOutput("reset_v1", v_1, '0);
    checkOutput("reset_v2", v_2, '0);
    checkOutput("reset_v3", v_3, '0);
    @(negedge clk);
    arst_n_in = 1'b1;
    applyStimulus();
    applyStimulus();
    checkQuiet("reset_release");

    seed = 0;
    runLoad(0, dc);
    checkOutput("done_cycle_plain", dc, FULL_LOAD_DONE);

    seed = 32'h1000;
    runLoad(1, dc);

    seed = 32'h2000;
    runLoad(2, dc);
    checkOutput("done_cycle_pokes", dc, FULL_LOAD_DONE);

    seed = 32'h3000;
    runLoad(3, dc);

    seed = 32'h4000;
    runLoad(0, dc);
    checkOutput("done_cycle_reload", dc, FULL_LOAD_DONE);

`ifdef KERNEL_LOADER_ABORT_EN
    seed = 32'h5000;
    runLoad(4, dc);
    seed = 32'h6000;
    runLoad(0, dc);
    checkOutput("done_cycle_after_abort", dc, FULL_LOAD_DONE);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
